priority_encoder_8_to_3: RTL and testbench

Registered 8-to-3 priority encoder with valid/ready handshakes on both sides, a two-entry output buffer and multi-hot error accounting. It is the encoding counterpart of the 3-to-8 decoder in the DECODER area. It turns eight request lines back into a 3-bit index plus status flags, for downstream logic that may stall.

---
 rtl/priority_encoder_8_to_3_if.sv | 44 ++++
 rtl/priority_encoder_8_to_3.sv | 97 +++++++++
 tb/tb_priority_encoder_8_to_3.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/priority_encoder_8_to_3_if.sv
// Handshake bundle for the registered 8-to-3 priority encoder.
// Ports: master = producer/consumer side (drives E, D, in_valid,
//   out_ready); slave = encoder side (drives in_ready, A, V, M,
//   out_valid, err_cnt).
interface priority_encoder_8_to_3_if #(
   parameter int ERR_W = 8
);
   logic             E;
   logic [7:0]       D;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       A;
   logic             V;
   logic             M;
   logic             out_valid;
   logic             out_ready;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output E,
      output D,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  A,
      input  V,
      input  M,
      input  out_valid,
      input  err_cnt
   );

   modport slave (
      input  E,
      input  D,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output A,
      output V,
      output M,
      output out_valid,
      output err_cnt
   );
endinterface

// File: rtl/priority_encoder_8_to_3.sv
// Registered 8-to-3 priority encoder, two-entry output FIFO.
// Ports: clk, rst (async active-high), bus (slave modport):
//   E/D/in_valid/in_ready on the input side,
//   A/V/M/out_valid/out_ready on the output side, err_cnt status.
module priority_encoder_8_to_3 #(
   parameter int ERR_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   priority_encoder_8_to_3_if.slave  bus
);

   typedef struct packed {
      logic [2:0] a;
      logic       v;
      logic       m;
   } ent_t;

   ent_t             head_q, head_d;
   ent_t             tail_q, tail_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;

   ent_t enc;
   logic push;
   logic pop;
   logic rdy;

   // Ascending scan: the last set bit seen wins, i.e. the highest.
   // D & (D-1) clears the lowest set bit; anything left means multi-hot.
   always_comb begin
      enc   = '0;
      for (int i = 0; i < 8; i++) begin
         if (bus.D[i]) enc.a = i[2:0];
      end
      enc.v = |bus.D;
      enc.m = |(bus.D & (bus.D - 8'd1));
   end

   // Kept low during reset so nothing is offered before release.
   assign rdy  = (cnt_q != 2'd2) & ~bus.E & ~rst;
   assign push = bus.in_valid & rdy;
   assign pop  = (cnt_q != 2'd0) & bus.out_ready;

   // head_q is always the visible entry; tail_q only holds the
   // second entry while count is 2.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      unique case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) head_d = enc;
            else               tail_d = enc;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            if (cnt_q == 2'd2) head_d = tail_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            // Only reachable at count 1: new entry replaces the head.
            head_d = enc;
         end
         default: ;
      endcase
   end

   always_comb begin
      err_d = err_q;
      if (push && enc.m && (err_q != {ERR_W{1'b1}})) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         err_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = (cnt_q != 2'd0);
   assign bus.A         = head_q.a;
   assign bus.V         = head_q.v;
   assign bus.M         = head_q.m;
   assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_priority_encoder_8_to_3.sv
// Self-checking bench for priority_encoder_8_to_3.
// Directed and random traffic against a queue-based reference model.
module tb_priority_encoder_8_to_3;

   logic clk;
   logic rst;

   priority_encoder_8_to_3_if #(.ERR_W(8)) bus ();
   priority_encoder_8_to_3_if #(.ERR_W(2)) bus2 ();

   priority_encoder_8_to_3 #(.ERR_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   priority_encoder_8_to_3 #(.ERR_W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: queue of expected {A,V,M} triples.
   logic [4:0] q[$];
   int         merr;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] ref_enc(input logic [7:0] d);
      int hi;
      int n;
      hi = 0;
      n  = $countones(d);
      for (int i = 7; i >= 0; i--) begin
         if (d[i]) begin
            hi = i;
            break;
         end
      end
      return {hi[2:0], n >= 1, n >= 2};
   endfunction

   // One cycle: drive at current time (just after negedge), check
   // in_ready, let the edge happen, then check outputs at the negedge.
   task automatic cycle(input logic e, input logic [7:0] d,
                        input logic iv, input logic ordy);
      logic exp_rdy;
      logic do_push;
      logic do_pop;
      bus.E         = e;
      bus.D         = d;
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      #1;
      exp_rdy = (q.size() < 2) && !e;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      do_push = iv && exp_rdy;
      do_pop  = ordy && (q.size() > 0);
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
         q.push_back(ref_enc(d));
         if ($countones(d) >= 2 && merr < 255) merr++;
      end
      @(negedge clk);
      chk("out_valid", {31'd0, bus.out_valid},
          {31'd0, q.size() != 0});
      if (q.size() != 0) begin
         chk("AVM", {27'd0, bus.A, bus.V, bus.M}, {27'd0, q[0]});
      end
      chk("err_cnt", {24'd0, bus.err_cnt}, merr);
   endtask

   logic [7:0] rd;
   int         sat;

   initial begin
      rst = 1'b1;
      bus.E = 1'b0;
      bus.D = 8'h00;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      bus2.E = 1'b0;
      bus2.D = 8'h00;
      bus2.in_valid = 1'b0;
      bus2.out_ready = 1'b1;
      merr = 0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_AVM", {27'd0, bus.A, bus.V, bus.M}, 32'd0);
      chk("rst_err", {24'd0, bus.err_cnt}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      rst = 1'b0;

      // One-hot sweep at full throughput
      for (int i = 0; i < 8; i++) cycle(1'b0, 8'h01 << i, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Zero and multi-hot
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b0, 8'hFF, 1'b1, 1'b1);
      cycle(1'b0, 8'b0010_0100, 1'b1, 1'b1);
      chk("err_two", {24'd0, bus.err_cnt}, 32'd2);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Backpressure
      cycle(1'b0, 8'h08, 1'b1, 1'b0);
      cycle(1'b0, 8'h40, 1'b1, 1'b0);
      chk("bp_A3", {29'd0, bus.A}, 32'd3);
      cycle(1'b0, 8'h01, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("bp_A6", {29'd0, bus.A}, 32'd6);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

      // Simultaneous push/pop at count 1
      cycle(1'b0, 8'h10, 1'b1, 1'b0);
      cycle(1'b0, 8'h02, 1'b1, 1'b1);
      chk("pp_A1", {29'd0, bus.A}, 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Disable while entries drain
      cycle(1'b0, 8'h80, 1'b1, 1'b0);
      cycle(1'b0, 8'h81, 1'b1, 1'b0);
      cycle(1'b1, 8'h04, 1'b1, 1'b1);
      cycle(1'b1, 8'h04, 1'b1, 1'b1);
      cycle(1'b1, 8'h04, 1'b1, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rd = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) rd = 8'h01 << $urandom_range(0, 7);
         if ($urandom_range(0, 7) == 0) rd = 8'h00;
         cycle($urandom_range(0, 9) == 0, rd,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end

      // Reset mid-operation with two entries buffered
      cycle(1'b0, 8'h20, 1'b1, 1'b0);
      cycle(1'b0, 8'h30, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mrst_err", {24'd0, bus.err_cnt}, 32'd0);
      chk("mrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      q.delete();
      merr = 0;
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 8'h04, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Saturation on the 2-bit counter instance
      sat = 0;
      for (int i = 0; i < 5; i++) begin
         bus2.D = 8'hC3;
         bus2.in_valid = 1'b1;
         @(posedge clk);
         if (sat < 3) sat++;
         @(negedge clk);
         chk("sat_err", {30'd0, bus2.err_cnt}, sat);
      end
      bus2.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("sat_hold", {30'd0, bus2.err_cnt}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
